// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the execute-stage result and control bits,
// and owns the architectural N/V/Z flag register read by the branch logic.
module ex_mem_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_W    = 4,
  parameter logic [2:0]  FLAG_RST = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [2:0]        ex_flag,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [REG_W-1:0]  rd_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [2:0]        flag,
  output logic [2:0]        flag_fwd
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] result_q,    result_d;
  logic [REG_W-1:0]  rd_q,        rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        flag_q,      flag_d;
  logic              accept;

  assign accept = in_valid & ~stall & ~flush;

  // Stage payload: load on accept, bubble when not stalled, otherwise hold.
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (!stall) begin
      if (accept) begin
        valid_d     = 1'b1;
        result_d    = ex_result;
        rd_d        = rd_in;
        reg_write_d = reg_write_in;
        mem_read_d  = mem_read_in;
        mem_write_d = mem_write_in;
      end else begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    end
  end

  // Flag update by opcode class; logical/shift ops only touch Z.
  always_comb begin
    flag_d = flag_q;
    if (accept) begin
      case (opcode)
        OP_ADD, OP_SUB:                 flag_d = ex_flag;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_d = {flag_q[2:1], ex_flag[0]};
        default:                        flag_d = flag_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      flag_q      <= FLAG_RST;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      flag_q      <= flag_d;
    end
  end

  // Bypass reflects reset too, so it always matches the flag after the edge.
  assign flag_fwd      = rst ? FLAG_RST : flag_d;
  assign out_valid     = valid_q;
  assign result        = result_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;
  assign mem_read_out  = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign flag          = flag_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: inputs driven and outputs sampled on the falling edge.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [3:0]  opcode;
  logic [15:0] ex_result;
  logic [2:0]  ex_flag;
  logic [3:0]  rd_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        out_valid;
  logic [15:0] result;
  logic [3:0]  rd_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [2:0]  flag;
  logic [2:0]  flag_fwd;

  int n_checks;
  int n_fails;

  ex_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .opcode       (opcode),
    .ex_result    (ex_result),
    .ex_flag      (ex_flag),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .out_valid    (out_valid),
    .result       (result),
    .rd_out       (rd_out),
    .reg_write_out(reg_write_out),
    .mem_read_out (mem_read_out),
    .mem_write_out(mem_write_out),
    .flag         (flag),
    .flag_fwd     (flag_fwd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic [2:0] fl, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw);
    in_valid     = v;
    opcode       = op;
    ex_result    = res;
    ex_flag      = fl;
    rd_in        = rd;
    reg_write_in = rw;
    mem_read_in  = mr;
    mem_write_in = mw;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] res,
                           input logic [3:0] rd, input logic rw, input logic mr,
                           input logic mw, input logic [2:0] fl);
    check_eq({tag, ".valid"}, 16'(out_valid), 16'(v));
    check_eq({tag, ".result"}, result, res);
    check_eq({tag, ".rd"}, 16'(rd_out), 16'(rd));
    check_eq({tag, ".rw"}, 16'(reg_write_out), 16'(rw));
    check_eq({tag, ".mr"}, 16'(mem_read_out), 16'(mr));
    check_eq({tag, ".mw"}, 16'(mem_write_out), 16'(mw));
    check_eq({tag, ".flag"}, 16'(flag), 16'(fl));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 4'b0000, 16'hFFFF, 3'b111, 4'd9, 1'b1, 1'b1, 1'b1);

    // Reset held for two cycles with a valid instruction presented.
    step();
    step();
    check_out("reset", 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;

    // ROR: result captured, Z cleared, N/V hold.
    drive(1'b1, 4'b0110, 16'h4123, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    check_out("ror", 1'b1, 16'h4123, 4'd3, 1'b1, 1'b0, 1'b0, 3'b000);

    // ADD preloads FLAG=110.
    drive(1'b1, 4'b0000, 16'h0042, 3'b110, 4'd1, 1'b1, 1'b0, 1'b0);
    #1 check_eq("add.fwd", 16'(flag_fwd), 16'(3'b110));
    step();
    check_out("add", 1'b1, 16'h0042, 4'd1, 1'b1, 1'b0, 1'b0, 3'b110);

    // SLL producing zero sets Z only; bypass visible before the edge.
    drive(1'b1, 4'b0100, 16'h0000, 3'b001, 4'd2, 1'b1, 1'b0, 1'b0);
    #1 check_eq("sll.fwd", 16'(flag_fwd), 16'(3'b111));
    check_eq("sll.pre_flag", 16'(flag), 16'(3'b110));
    step();
    check_out("sll", 1'b1, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 3'b111);

    // XOR clears Z only.
    drive(1'b1, 4'b0010, 16'h00F0, 3'b100, 4'd4, 1'b1, 1'b0, 1'b0);
    step();
    check_out("xor", 1'b1, 16'h00F0, 4'd4, 1'b1, 1'b0, 1'b0, 3'b110);

    // PADDSB leaves FLAG alone.
    drive(1'b1, 4'b0011, 16'h7F80, 3'b111, 4'd5, 1'b1, 1'b0, 1'b0);
    #1 check_eq("paddsb.fwd", 16'(flag_fwd), 16'(3'b110));
    step();
    check_out("paddsb", 1'b1, 16'h7F80, 4'd5, 1'b1, 1'b0, 1'b0, 3'b110);

    // Load then store: controls pass through, FLAG holds.
    drive(1'b1, 4'b1000, 16'h0100, 3'b001, 4'd6, 1'b1, 1'b1, 1'b0);
    step();
    check_out("load", 1'b1, 16'h0100, 4'd6, 1'b1, 1'b1, 1'b0, 3'b110);
    drive(1'b1, 4'b1001, 16'h0200, 3'b011, 4'd8, 1'b0, 1'b0, 1'b1);
    step();
    check_out("store", 1'b1, 16'h0200, 4'd8, 1'b0, 1'b0, 1'b1, 3'b110);

    // SUB under stall for 3 cycles: everything holds.
    drive(1'b1, 4'b0001, 16'h1111, 3'b010, 4'd7, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall.fwd", 16'(flag_fwd), 16'(3'b110));
      step();
      check_out("stall", 1'b1, 16'h0200, 4'd8, 1'b0, 1'b0, 1'b1, 3'b110);
    end

    // Flush on release: bubble, FLAG keeps pre-SUB value, result/rd hold.
    stall = 1'b0;
    flush = 1'b1;
    #1 check_eq("flush.fwd", 16'(flag_fwd), 16'(3'b110));
    step();
    check_out("flush", 1'b0, 16'h0200, 4'd8, 1'b0, 1'b0, 1'b0, 3'b110);
    flush = 1'b0;

    // Invalid input is a bubble and never touches FLAG.
    drive(1'b0, 4'b0000, 16'hDEAD, 3'b111, 4'd10, 1'b1, 1'b1, 1'b1);
    step();
    check_out("invalid", 1'b0, 16'h0200, 4'd8, 1'b0, 1'b0, 1'b0, 3'b110);

    // Back-to-back ADD, XOR, SRA at full throughput.
    drive(1'b1, 4'b0000, 16'hA000, 3'b100, 4'd11, 1'b1, 1'b0, 1'b0);
    step();
    check_out("b2b.add", 1'b1, 16'hA000, 4'd11, 1'b1, 1'b0, 1'b0, 3'b100);
    drive(1'b1, 4'b0010, 16'h0000, 3'b001, 4'd12, 1'b1, 1'b0, 1'b0);
    step();
    check_out("b2b.xor", 1'b1, 16'h0000, 4'd12, 1'b1, 1'b0, 1'b0, 3'b101);
    drive(1'b1, 4'b0101, 16'hF000, 3'b000, 4'd13, 1'b1, 1'b0, 1'b0);
    step();
    check_out("b2b.sra", 1'b1, 16'hF000, 4'd13, 1'b1, 1'b0, 1'b0, 3'b100);
    drive(1'b0, 4'b0000, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("b2b.drain", 16'(out_valid), 16'(1'b0));

    // Reset during a stall still wins.
    drive(1'b1, 4'b0000, 16'h5555, 3'b111, 4'd14, 1'b1, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    rst = 1'b1;
    step();
    check_out("rst_stall", 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register directly downstream of the execute stage (shifter and ALU).
- Captures the 16-bit result, destination/control info and raw N/V/Z flags, and presents them to the memory stage.
- Owns the architectural flag register (FLAG), updated per opcode class, which the branch logic reads.
- Supports stall, flush and bubble propagation.

Parameters:
DATA_W, 16, datapath width of result
REG_W, 4, register-index width
FLAG_RST, 3'b000, reset value of FLAG {N,V,Z}

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  hold all stage state this cycle
flush  input  1  squash the incoming instruction (insert a bubble)
in_valid  input  1  execute stage presents a real instruction
opcode  input  4  instruction opcode of the incoming instruction
ex_result  input  DATA_W  shifter/ALU result
ex_flag  input  3  raw flags from execute: [2]=N, [1]=V, [0]=Z
rd_in  input  REG_W  destination register
reg_write_in  input  1  register-write enable
mem_read_in  input  1  load
mem_write_in  input  1  store
out_valid  output  1  stage holds a real instruction
result  output  DATA_W  registered result
rd_out  output  REG_W  registered destination
reg_write_out  output  1  registered write enable (gated by valid)
mem_read_out  output  1  registered load (gated by valid)
mem_write_out  output  1  registered store (gated by valid)
flag  output  3  architectural FLAG {N,V,Z}
flag_fwd  output  3  value FLAG will take at the next edge (bypass to branch logic)

Behaviour:
- All state updates on the rising clk edge.
- Priority per cycle: rst > stall > flush > load.
- Reset values:
  - out_valid, result, rd_out and all *_out controls = 0.
  - flag = FLAG_RST.
  - Reset mid-stall or mid-flush wins unconditionally.
- Load condition: the stage accepts the input when `accept = in_valid & ~stall & ~flush`.
- On accept:
  - out_valid <= 1.
  - result <= ex_result, rd_out <= rd_in.
  - Controls <= their inputs.
- Bubble: when `~stall & (flush | ~in_valid)`, out_valid <= 0 and all *_out controls <= 0. result and rd_out keep their old values; they are don't-care while invalid.
- Stall: every register holds, FLAG included. Stall takes priority over flush, so a flush asserted during a stall has no effect. Upstream must re-present the flush after the stall.
- FLAG update occurs only on accept, per opcode class:
  - 0000 ADD, 0001 SUB: N, V, Z all <= ex_flag.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z <= ex_flag[0]; N and V hold.
  - All other opcodes (PADDSB, RED, memory, branch, etc.): FLAG holds.
- flag_fwd is combinational: it equals the next-state value of FLAG under the rules above, and equals flag when there is no accept.
- Output latency: exactly one cycle from accept to out_valid/result.
- Back-to-back accepts run at full throughput with no gaps.
- An invalid or flushed instruction never alters FLAG and never raises reg_write_out, mem_read_out or mem_write_out.

Test Plan:
- Reset check: assert rst for 2 cycles during in_valid=1 → out_valid=0, result=0x0000, controls=0, flag=000.
- ROR result: opcode=0110, ex_result=0x4123 (0x1234 rotated right by 4), ex_flag=3'b000, rd_in=3, reg_write_in=1 → next cycle out_valid=1, result=0x4123, rd_out=3, reg_write_out=1, flag[0]=0, N and V unchanged.
- Shift sets Z:
  - Preload FLAG=3'b110 via ADD with ex_flag=110.
  - Then SLL with ex_result=0x0000 (0x1234 shifted left by 15 would give 0x0000) and ex_flag=3'b001 → flag=3'b111; flag_fwd=111 in the accept cycle, before the edge.
- No-update opcode: PADDSB (0011) with ex_flag=3'b111 → flag unchanged and result captured.
- Stall and flush: SUB with ex_flag=3'b010 and stall=1 for 3 cycles, then flush=1 on release → all outputs and flag hold during the stall; after the flush edge out_valid=0, reg_write_out=0, flag still holds its pre-SUB value.
- Back-to-back: ADD (flag 100), XOR (flag 001), SRA (flag 000) on consecutive cycles → out_valid stays 1 for 3 cycles and flag sequence = 100, 101, 100.
